// File: rtl/axi4_fw_pkg.sv
// ---------------------------------------------------------------------------
// axi4_fw_pkg
// Shared types for the AXI4 region firewall decoder: config FSM states,
// response error codes and the programmable region table entry.
//
// Region entry fields use fixed maximum widths so one package serves every
// parameterisation of the decoder. Narrower configurations zero-extend into
// these fields, and the unused upper bits reduce to constants in synthesis.
// Supported limits: ADDR_WIDTH <= 64, NUM_MASTERS <= 16, NUM_SLAVES <= 16.
// ---------------------------------------------------------------------------
package axi4_fw_pkg;

    localparam int unsigned FW_AW_MAX    = 64;  // widest supported address
    localparam int unsigned FW_NM_MAX    = 16;  // most supported masters
    localparam int unsigned FW_NM_IDX_W  = 4;   // index width into FW_NM_MAX
    localparam int unsigned FW_SW_MAX    = 4;   // widest slave index

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        OPEN   = 2'd1,
        SEALED = 2'd2
    } fw_state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_NOMATCH  = 2'd1,
        ERR_PERM     = 2'd2,
        ERR_SECURITY = 2'd3
    } fw_err_t;

    typedef struct packed {
        logic                 valid;
        logic [FW_AW_MAX-1:0] base;
        logic [FW_AW_MAX-1:0] mask;
        logic [FW_SW_MAX-1:0] slave;
        logic [FW_NM_MAX-1:0] rperm;
        logic [FW_NM_MAX-1:0] wperm;
        logic                 sec_only;
        logic                 priv_only;
    } fw_region_t;

endpackage

// File: rtl/axi4_fw_region_match.sv
// ---------------------------------------------------------------------------
// axi4_fw_region_match
// Purely combinational evaluation of one region table entry against the
// request that currently sits in the first pipeline stage.
//
// Ports:
//   entry_i    region table entry
//   addr_i     request address
//   prot_i     AxPROT[1:0] (bit 1 = non-secure, bit 0 = privileged)
//   write_i    1 = write request, 0 = read request
//   mid_i      master id
//   hit_o      entry valid and address matches base under mask
//   perm_ok_o  the master holds the read/write permission for this region
//   sec_ok_o   the request satisfies the secure/privileged attributes
//   sel_o      one-hot slave select for this region
// ---------------------------------------------------------------------------
module axi4_fw_region_match
    import axi4_fw_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned MID_W      = 2
) (
    input  fw_region_t             entry_i,
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [1:0]             prot_i,
    input  logic                   write_i,
    input  logic [MID_W-1:0]       mid_i,
    output logic                   hit_o,
    output logic                   perm_ok_o,
    output logic                   sec_ok_o,
    output logic [NUM_SLAVES-1:0]  sel_o
);

    logic [FW_AW_MAX-1:0] addr_ext;
    logic [FW_NM_MAX-1:0] perm_vec;

    assign addr_ext = FW_AW_MAX'(addr_i);
    assign hit_o    = entry_i.valid &&
                      ((addr_ext & entry_i.mask) == (entry_i.base & entry_i.mask));

    // Permission bits above NUM_MASTERS are always zero in the table, so an
    // out-of-range master id naturally reads a 0 and is refused.
    assign perm_vec  = write_i ? entry_i.wperm : entry_i.rperm;
    assign perm_ok_o = perm_vec[FW_NM_IDX_W'(mid_i)];

    assign sec_ok_o  = !(entry_i.sec_only  &&  prot_i[1]) &&
                       !(entry_i.priv_only && !prot_i[0]);

    assign sel_o     = NUM_SLAVES'(1) << entry_i.slave;

endmodule

// File: rtl/axi4_region_firewall_decoder.sv
// ---------------------------------------------------------------------------
// axi4_region_firewall_decoder
// Programmable AXI4 address firewall between master arbitration and the
// slave mux. Decodes one AW/AR request per cycle through a two-stage
// valid/ready pipeline against a base/mask region table with per-master
// permissions and secure/privileged attributes. Includes a LOCKED/OPEN/SEALED
// config FSM, a sticky tamper flag, first-violation capture and a saturating
// violation counter. NUM_REGIONS and NUM_SLAVES must be at least 2.
//
// Ports:
//   aclk, aresetn                 clock, async active-low reset
//   req_valid/req_ready           request handshake
//   req_addr/prot/write/mid       request attributes
//   rsp_valid/rsp_ready           response handshake
//   rsp_sel/rsp_err/rsp_write     one-hot slave select, error code, AW/AR
//   cfg_en/cfg_we/cfg_seal        open config, write table entry, seal
//   cfg_idx/base/mask/slave/...   table entry write data
//   viol_clr                      clear violation counter and capture
//   cfg_state                     config FSM state
//   viol_count/addr/info          violation counter and first-violation log
//   tamper, irq                   sticky illegal-write flag, interrupt
// ---------------------------------------------------------------------------
module axi4_region_firewall_decoder
    import axi4_fw_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH  = 32,
    parameter  int unsigned NUM_REGIONS = 8,
    parameter  int unsigned NUM_SLAVES  = 4,
    parameter  int unsigned NUM_MASTERS = 4,
    parameter  int unsigned CNT_W       = 16,
    localparam int unsigned MID_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int unsigned IDX_W       = $clog2(NUM_REGIONS),
    localparam int unsigned SLV_W       = $clog2(NUM_SLAVES)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2:0]              req_prot,
    input  logic                    req_write,
    input  logic [MID_W-1:0]        req_mid,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [NUM_SLAVES-1:0]   rsp_sel,
    output logic [1:0]              rsp_err,
    output logic                    rsp_write,
    input  logic                    cfg_en,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [ADDR_WIDTH-1:0]   cfg_base,
    input  logic [ADDR_WIDTH-1:0]   cfg_mask,
    input  logic [SLV_W-1:0]        cfg_slave,
    input  logic [NUM_MASTERS-1:0]  cfg_rperm,
    input  logic [NUM_MASTERS-1:0]  cfg_wperm,
    input  logic                    cfg_sec_only,
    input  logic                    cfg_priv_only,
    input  logic                    cfg_valid_bit,
    input  logic                    cfg_seal,
    input  logic                    viol_clr,
    output logic [1:0]              cfg_state,
    output logic [CNT_W-1:0]        viol_count,
    output logic [ADDR_WIDTH-1:0]   viol_addr,
    output logic [2+MID_W:0]        viol_info,
    output logic                    tamper,
    output logic                    irq
);

    // Bit i is set when table index i exists; covers non-power-of-two tables.
    localparam logic [(2**IDX_W)-1:0] IDX_LEGAL =
        {(2**IDX_W){1'b1}} >> ((2**IDX_W) - NUM_REGIONS);

    // ---------------- config FSM and tamper ----------------
    fw_state_t  state_q, state_d;
    logic       tamper_q;
    logic       tbl_we, bad_we;

    assign tbl_we = cfg_we && (state_q == OPEN) && IDX_LEGAL[cfg_idx];
    assign bad_we = cfg_we && !tbl_we;

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= LOCKED;
            tamper_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (bad_we) tamper_q <= 1'b1;
        end
    end

    // NOTE: next state defaults to the current state first, so no path
    // through the case leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOCKED:  if (cfg_en) state_d = OPEN;
            OPEN: begin
                // Seal wins over dropping cfg_en in the same cycle.
                if (cfg_seal)     state_d = SEALED;
                else if (!cfg_en) state_d = LOCKED;
            end
            SEALED:  state_d = SEALED;
            default: state_d = LOCKED;
        endcase
    end

    // ---------------- region table ----------------
    fw_region_t table_q [NUM_REGIONS];
    fw_region_t wr_entry;

    assign wr_entry = '{valid:     cfg_valid_bit,
                        base:      FW_AW_MAX'(cfg_base),
                        mask:      FW_AW_MAX'(cfg_mask),
                        slave:     FW_SW_MAX'(cfg_slave),
                        rperm:     FW_NM_MAX'(cfg_rperm),
                        wperm:     FW_NM_MAX'(cfg_wperm),
                        sec_only:  cfg_sec_only,
                        priv_only: cfg_priv_only};

    // NOTE: the table is a small flop array that is reset deliberately: every
    // entry must come up invalid so all requests are refused until configured.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int r = 0; r < NUM_REGIONS; r++) table_q[r] <= '0;
        end else if (tbl_we) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if (cfg_idx == IDX_W'(r)) table_q[r] <= wr_entry;
            end
        end
    end

    // ---------------- pipeline stage 1: request register ----------------
    logic                   s1_valid_q, s1_write_q;
    logic [ADDR_WIDTH-1:0]  s1_addr_q;
    logic [1:0]             s1_prot_q;
    logic [MID_W-1:0]       s1_mid_q;
    logic                   s1_free, s2_free;
    logic                   rsp_valid_q;

    assign s2_free   = !rsp_valid_q || rsp_ready;
    assign s1_free   = !s1_valid_q  || s2_free;
    assign req_ready = s1_free;

    // AxPROT[2] (instruction/data) plays no part in the access decision.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_prot_q  <= '0;
            s1_write_q <= 1'b0;
            s1_mid_q   <= '0;
        end else if (s1_free) begin
            s1_valid_q <= req_valid;
            if (req_valid) begin
                s1_addr_q  <= req_addr;
                s1_prot_q  <= req_prot[1:0];
                s1_write_q <= req_write;
                s1_mid_q   <= req_mid;
            end
        end
    end

    // ---------------- decode: per-region match + priority ----------------
    logic [NUM_REGIONS-1:0] hit, perm_ok, sec_ok;
    logic [NUM_SLAVES-1:0]  reg_sel [NUM_REGIONS];
    fw_err_t                dec_err;
    logic [NUM_SLAVES-1:0]  dec_sel;

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
        axi4_fw_region_match #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_SLAVES (NUM_SLAVES),
            .MID_W      (MID_W)
        ) u_match (
            .entry_i    (table_q[r]),
            .addr_i     (s1_addr_q),
            .prot_i     (s1_prot_q),
            .write_i    (s1_write_q),
            .mid_i      (s1_mid_q),
            .hit_o      (hit[r]),
            .perm_ok_o  (perm_ok[r]),
            .sec_ok_o   (sec_ok[r]),
            .sel_o      (reg_sel[r])
        );
    end

    // Scan from the highest index down so the lowest-index hit is applied last.
    always_comb begin
        dec_err = ERR_NOMATCH;
        dec_sel = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (hit[r]) begin
                dec_sel = '0;
                if (!perm_ok[r])     dec_err = ERR_PERM;
                else if (!sec_ok[r]) dec_err = ERR_SECURITY;
                else begin
                    dec_err = ERR_OK;
                    dec_sel = reg_sel[r];
                end
            end
        end
    end

    // ---------------- pipeline stage 2: response register ----------------
    fw_err_t                rsp_err_q;
    logic [NUM_SLAVES-1:0]  rsp_sel_q;
    logic                   rsp_write_q;
    logic [ADDR_WIDTH-1:0]  rsp_addr_q;
    logic [MID_W-1:0]       rsp_mid_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= ERR_OK;
            rsp_sel_q   <= '0;
            rsp_write_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_mid_q   <= '0;
        end else if (s2_free) begin
            rsp_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rsp_err_q   <= dec_err;
                rsp_sel_q   <= dec_sel;
                rsp_write_q <= s1_write_q;
                rsp_addr_q  <= s1_addr_q;
                rsp_mid_q   <= s1_mid_q;
            end
        end
    end

    // ---------------- violation logging ----------------
    logic                   viol_hs;
    logic [CNT_W-1:0]       viol_count_q;
    logic [ADDR_WIDTH-1:0]  viol_addr_q;
    logic [2+MID_W:0]       viol_info_q;

    assign viol_hs = rsp_valid_q && rsp_ready && (rsp_err_q != ERR_OK);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            viol_count_q <= '0;
            viol_addr_q  <= '0;
            viol_info_q  <= '0;
        end else if (viol_clr) begin
            // A violation retiring in the clear cycle survives as the first one.
            viol_count_q <= viol_hs ? CNT_W'(1) : '0;
            viol_addr_q  <= viol_hs ? rsp_addr_q : '0;
            viol_info_q  <= viol_hs ? {rsp_err_q, rsp_write_q, rsp_mid_q} : '0;
        end else if (viol_hs) begin
            if (viol_count_q != '1) viol_count_q <= viol_count_q + CNT_W'(1);
            if (viol_count_q == '0) begin
                viol_addr_q <= rsp_addr_q;
                viol_info_q <= {rsp_err_q, rsp_write_q, rsp_mid_q};
            end
        end
    end

    // ---------------- outputs ----------------
    assign rsp_valid  = rsp_valid_q;
    assign rsp_sel    = rsp_sel_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_write  = rsp_write_q;
    assign cfg_state  = state_q;
    assign viol_count = viol_count_q;
    assign viol_addr  = viol_addr_q;
    assign viol_info  = viol_info_q;
    assign tamper     = tamper_q;
    assign irq        = (viol_count_q != '0) || tamper_q;

endmodule

// File: tb/tb_axi4_region_firewall_decoder.sv
// ---------------------------------------------------------------------------
// tb_axi4_region_firewall_decoder
// Directed self-checking bench for the region firewall decoder (default
// parameters: 32-bit address, 8 regions, 4 slaves, 4 masters, 16-bit counter).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// A request presented after edge N is captured at N+1 and answered after N+2.
// ---------------------------------------------------------------------------
module tb_axi4_region_firewall_decoder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_prot;
    logic        req_write;
    logic [1:0]  req_mid;
    logic        rsp_valid, rsp_ready;
    logic [3:0]  rsp_sel;
    logic [1:0]  rsp_err;
    logic        rsp_write;
    logic        cfg_en, cfg_we;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_base, cfg_mask;
    logic [1:0]  cfg_slave;
    logic [3:0]  cfg_rperm, cfg_wperm;
    logic        cfg_sec_only, cfg_priv_only, cfg_valid_bit, cfg_seal;
    logic        viol_clr;
    logic [1:0]  cfg_state;
    logic [15:0] viol_count;
    logic [31:0] viol_addr;
    logic [4:0]  viol_info;
    logic        tamper, irq;

    axi4_region_firewall_decoder dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_prot      (req_prot),
        .req_write     (req_write),
        .req_mid       (req_mid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_sel       (rsp_sel),
        .rsp_err       (rsp_err),
        .rsp_write     (rsp_write),
        .cfg_en        (cfg_en),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_base      (cfg_base),
        .cfg_mask      (cfg_mask),
        .cfg_slave     (cfg_slave),
        .cfg_rperm     (cfg_rperm),
        .cfg_wperm     (cfg_wperm),
        .cfg_sec_only  (cfg_sec_only),
        .cfg_priv_only (cfg_priv_only),
        .cfg_valid_bit (cfg_valid_bit),
        .cfg_seal      (cfg_seal),
        .viol_clr      (viol_clr),
        .cfg_state     (cfg_state),
        .viol_count    (viol_count),
        .viol_addr     (viol_addr),
        .viol_info     (viol_info),
        .tamper        (tamper),
        .irq           (irq)
    );

    always #5 aclk = ~aclk;

    localparam logic [1:0] E_OK = 2'd0, E_NOM = 2'd1, E_PERM = 2'd2, E_SEC = 2'd3;

    // Back-to-back stall scenario: four requests with hand-computed answers.
    localparam logic [31:0] S_ADDR [4] = '{32'h8000_0000, 32'h8000_0000, 32'hA000_0000, 32'h9000_0000};
    localparam logic [2:0]  S_PROT [4] = '{3'b000, 3'b000, 3'b000, 3'b001};
    localparam logic        S_WR   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [1:0]  S_MID  [4] = '{2'd0, 2'd1, 2'd0, 2'd3};
    localparam logic [1:0]  S_ERR  [4] = '{E_OK, E_PERM, E_NOM, E_OK};
    localparam logic [3:0]  S_SEL  [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b1000};

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model of the violation log, advanced by run_req().
    int unsigned exp_cnt   = 0;
    logic [31:0] exp_vaddr = '0;
    logic [4:0]  exp_vinfo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [31:0] base, input logic [31:0] mask,
                             input logic [1:0] slave, input logic [3:0] rperm, input logic [3:0] wperm,
                             input logic sec, input logic priv);
        cfg_we = 1'b1; cfg_idx = idx; cfg_base = base; cfg_mask = mask; cfg_slave = slave;
        cfg_rperm = rperm; cfg_wperm = wperm; cfg_sec_only = sec; cfg_priv_only = priv;
        cfg_valid_bit = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    // One isolated request through an empty pipeline with rsp_ready held high.
    task automatic run_req(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                           input logic wr, input logic [1:0] mid,
                           input logic [1:0] err, input logic [3:0] sel);
        req_addr = addr; req_prot = prot; req_write = wr; req_mid = mid; req_valid = 1'b1;
        #1 check({tag, ".req_ready"}, 64'(req_ready), 64'(1'b1));
        tick();
        req_valid = 1'b0;
        check({tag, ".lat1"}, 64'(rsp_valid), 64'(1'b0));
        tick();
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(1'b1));
        check({tag, ".rsp_err"},   64'(rsp_err),   64'(err));
        check({tag, ".rsp_sel"},   64'(rsp_sel),   64'(sel));
        check({tag, ".rsp_write"}, 64'(rsp_write), 64'(wr));
        if (err != E_OK) begin
            if (exp_cnt == 0) begin
                exp_vaddr = addr;
                exp_vinfo = {err, wr, mid};
            end
            exp_cnt++;
        end
        tick();
        check({tag, ".viol_count"}, 64'(viol_count), 64'(exp_cnt));
        check({tag, ".drained"},    64'(rsp_valid),  64'(1'b0));
    endtask

    task automatic drive_stall_req(input int i);
        req_valid = 1'b1; req_addr = S_ADDR[i]; req_prot = S_PROT[i];
        req_write = S_WR[i]; req_mid = S_MID[i];
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc;
        int ridx;
        logic rr, hs, acc;

        aresetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_prot = '0; req_write = 1'b0;
        req_mid = '0; rsp_ready = 1'b1; cfg_en = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_base = '0; cfg_mask = '0; cfg_slave = '0; cfg_rperm = '0; cfg_wperm = '0;
        cfg_sec_only = 1'b0; cfg_priv_only = 1'b0; cfg_valid_bit = 1'b0; cfg_seal = 1'b0;
        viol_clr = 1'b0;

        // ---- reset values ----
        #12;
        check("rst.req_ready",  64'(req_ready),  64'(1'b1));
        check("rst.rsp_valid",  64'(rsp_valid),  64'(1'b0));
        check("rst.rsp_sel",    64'(rsp_sel),    64'(4'b0));
        check("rst.rsp_err",    64'(rsp_err),    64'(2'b0));
        check("rst.rsp_write",  64'(rsp_write),  64'(1'b0));
        check("rst.cfg_state",  64'(cfg_state),  64'(2'd0));
        check("rst.viol_count", 64'(viol_count), 64'(16'd0));
        check("rst.viol_addr",  64'(viol_addr),  64'(32'd0));
        check("rst.viol_info",  64'(viol_info),  64'(5'd0));
        check("rst.tamper",     64'(tamper),     64'(1'b0));
        check("rst.irq",        64'(irq),        64'(1'b0));
        aresetn = 1'b1;
        tick();

        // ---- empty table: everything is NOMATCH ----
        run_req("nomatch0", 32'h8000_0000, 3'b000, 1'b0, 2'd0, E_NOM, 4'b0000);
        check("nomatch0.viol_addr", 64'(viol_addr), 64'(32'h8000_0000));
        check("nomatch0.viol_info", 64'(viol_info), 64'(5'b01_0_00));
        check("nomatch0.irq",       64'(irq),       64'(1'b1));

        viol_clr = 1'b1;
        tick();
        viol_clr = 1'b0;
        exp_cnt = 0; exp_vaddr = '0; exp_vinfo = '0;
        check("clr.viol_count", 64'(viol_count), 64'(16'd0));
        check("clr.viol_addr",  64'(viol_addr),  64'(32'd0));
        check("clr.irq",        64'(irq),        64'(1'b0));

        // ---- program the table ----
        cfg_en = 1'b1;
        tick();
        check("cfg.open", 64'(cfg_state), 64'(2'd1));
        cfg_write(3'd0, 32'h8000_0000, 32'hF000_0000, 2'd0, 4'b0001, 4'b0000, 1'b0, 1'b0);
        cfg_write(3'd1, 32'h9000_0000, 32'hFC00_0000, 2'd3, 4'b1111, 4'b1111, 1'b1, 1'b1);
        cfg_write(3'd2, 32'h8000_0000, 32'hFFF0_0000, 2'd2, 4'b1111, 4'b1111, 1'b0, 1'b0);
        cfg_en = 1'b0;
        tick();
        check("cfg.locked", 64'(cfg_state), 64'(2'd0));
        check("cfg.no_tamper", 64'(tamper), 64'(1'b0));

        // ---- permissions, overlap priority, security attributes ----
        run_req("rd_mid0",    32'h8000_0004, 3'b000, 1'b0, 2'd0, E_OK,   4'b0001);
        run_req("rd_mid1",    32'h8000_0004, 3'b000, 1'b0, 2'd1, E_PERM, 4'b0000);
        run_req("overlap",    32'h8000_0010, 3'b000, 1'b0, 2'd0, E_OK,   4'b0001);
        run_req("wr_noperm",  32'h8000_0010, 3'b000, 1'b1, 2'd0, E_PERM, 4'b0000);
        run_req("sec_ns",     32'h9000_0000, 3'b010, 1'b1, 2'd2, E_SEC,  4'b0000);
        run_req("sec_unpriv", 32'h9000_0000, 3'b000, 1'b1, 2'd2, E_SEC,  4'b0000);
        run_req("sec_ok",     32'h9000_0100, 3'b001, 1'b1, 2'd2, E_OK,   4'b1000);
        run_req("mask_edge",  32'h9400_0000, 3'b001, 1'b1, 2'd2, E_NOM,  4'b0000);
        run_req("unmapped",   32'hA000_0000, 3'b000, 1'b0, 2'd3, E_NOM,  4'b0000);
        check("log.viol_addr", 64'(viol_addr), 64'(exp_vaddr));
        check("log.viol_info", 64'(viol_info), 64'(exp_vinfo));

        // ---- seal (seal beats cfg_en=0), then attempt a write ----
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0; cfg_seal = 1'b1;
        tick();
        cfg_seal = 1'b0;
        check("seal.state", 64'(cfg_state), 64'(2'd2));
        tick();
        check("seal.stays", 64'(cfg_state), 64'(2'd2));
        cfg_en = 1'b1;
        cfg_write(3'd0, 32'h8000_0000, 32'hF000_0000, 2'd1, 4'b1111, 4'b1111, 1'b0, 1'b0);
        cfg_en = 1'b0;
        tick();
        check("seal.state_after_we", 64'(cfg_state), 64'(2'd2));
        check("seal.tamper",         64'(tamper),    64'(1'b1));
        check("seal.irq",            64'(irq),       64'(1'b1));
        run_req("seal.table_kept", 32'h8000_0004, 3'b000, 1'b0, 2'd0, E_OK, 4'b0001);

        // ---- backpressure: rsp_ready low for 5 cycles, 4 back-to-back ----
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 5; c++) begin
            if (n_acc < 4) drive_stall_req(n_acc);
            #1 rr = req_ready;
            if (c == 2) check("stall.req_ready_drop", 64'(rr), 64'(1'b0));
            tick();
            if (rr) n_acc++;
            if (c >= 1) begin
                check($sformatf("stall.hold_valid%0d", c), 64'(rsp_valid), 64'(1'b1));
                check($sformatf("stall.hold_rsp%0d", c),
                      64'({rsp_err, rsp_sel, rsp_write}), 64'({S_ERR[0], S_SEL[0], S_WR[0]}));
            end
        end
        check("stall.accepted", 64'(n_acc), 64'(2));

        // Drain in order; clear the log in the same cycle the NOMATCH retires.
        rsp_ready = 1'b1;
        ridx = 0;
        for (int c = 0; c < 20 && ridx < 4; c++) begin
            if (n_acc < 4) drive_stall_req(n_acc);
            else req_valid = 1'b0;
            viol_clr = rsp_valid && (ridx == 2);
            #1;
            hs  = rsp_valid;
            acc = req_valid && req_ready;
            if (hs) check($sformatf("drain.rsp%0d", ridx),
                          64'({rsp_err, rsp_sel, rsp_write}), 64'({S_ERR[ridx], S_SEL[ridx], S_WR[ridx]}));
            tick();
            if (acc) n_acc++;
            if (hs)  ridx++;
        end
        req_valid = 1'b0;
        viol_clr  = 1'b0;
        check("drain.count", 64'(ridx), 64'(4));
        check("clr_hs.viol_count", 64'(viol_count), 64'(16'd1));
        check("clr_hs.viol_addr",  64'(viol_addr),  64'(32'hA000_0000));
        check("clr_hs.viol_info",  64'(viol_info),  64'(5'b01_0_00));

        // ---- reset with a request in flight: no response appears ----
        req_valid = 1'b1; req_addr = 32'h8000_0000; req_prot = '0; req_write = 1'b0; req_mid = '0;
        tick();
        req_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        check("midrst.rsp_valid", 64'(rsp_valid), 64'(1'b0));
        check("midrst.req_ready", 64'(req_ready), 64'(1'b1));
        check("midrst.tamper",    64'(tamper),    64'(1'b0));
        check("midrst.state",     64'(cfg_state), 64'(2'd0));
        tick();
        aresetn = 1'b1;
        tick();
        tick();
        tick();
        check("midrst.no_rsp", 64'(rsp_valid), 64'(1'b0));
        check("midrst.count",  64'(viol_count), 64'(16'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
